// File: rtl/sram_1rw1r_wmask_model.sv
// Behavioural 1RW+1R SRAM with per-lane write mask and post-reset zero-clear; reads have 1-cycle latency.
// No backpressure: requests made while init_busy is high are dropped, outputs hold.
module sram_1rw1r_wmask_model #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter int NUM_WMASKS     = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  init_busy
);

  localparam int LANE_W    = DATA_WIDTH / NUM_WMASKS;
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [ADDR_WIDTH-1:0]   clr_addr_nxt;
  logic                    clr_we;
  logic                    usr_we;
  logic                    rd0;
  logic                    rd1;
  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    clr_we       = 1'b0;
    usr_we       = 1'b0;
    rd0          = 1'b0;
    rd1          = 1'b0;
    if (rst_n) begin
      case (state)
        ST_CLEAR: begin
          if (CLEAR_ON_RESET != 0) begin
            clr_we       = 1'b1;
            clr_addr_nxt = clr_addr + ADDR_WIDTH'(1);
            if (&clr_addr) state_nxt = ST_READY;
          end else begin
            state_nxt = ST_READY;
          end
        end
        ST_READY: begin
          usr_we = !csb0 && !web0;
          rd0    = !csb0 && web0;
          rd1    = !csb1;
        end
        default: state_nxt = ST_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      dout0    <= '0;
      dout1    <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
      if (rd0) dout0 <= mem[addr0];
      if (rd1) dout1 <= mem[addr1];
    end
  end

  // Reads above sample the pre-edge array, so a same-address write here is read-before-write.
  always_ff @(posedge clk0) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (usr_we) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) mem[addr0][i*LANE_W +: LANE_W] <= din0[i*LANE_W +: LANE_W];
      end
    end
  end

  assign init_busy = (state != ST_READY);

endmodule

// File: tb/tb_sram_1rw1r_wmask_model.sv
// Randomised and directed bench for sram_1rw1r_wmask_model against an array-based reference.
module tb_sram_1rw1r_wmask_model;
  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int NM    = 4;
  localparam int DEPTH = 128;

  logic          clk0 = 1'b0;
  logic          rst_n;
  logic          csb0;
  logic          web0;
  logic [NM-1:0] wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic          csb1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] dout0;
  logic [DW-1:0] dout1;
  logic          init_busy;
  logic [DW-1:0] nc_dout0;
  logic [DW-1:0] nc_dout1;
  logic          nc_init_busy;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] exp_d0;
  logic [DW-1:0] exp_d1;
  bit            mdl_ready;

  always #5 clk0 = ~clk0;

  sram_1rw1r_wmask_model #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM), .CLEAR_ON_RESET(1)) dut (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0), .csb1(csb1), .addr1(addr1), .dout1(dout1), .init_busy(init_busy)
  );

  sram_1rw1r_wmask_model #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM), .CLEAR_ON_RESET(0)) dut_nc (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(nc_dout0), .csb1(csb1), .addr1(addr1), .dout1(nc_dout1), .init_busy(nc_init_busy)
  );

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic idle_inputs();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; addr1 = '0;
  endtask

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
    exp_d0 = '0;
    exp_d1 = '0;
  endtask

  // One clock of requests; the reference is updated only when it believes the RAM is ready.
  task automatic drive_cycle(input bit c0, input bit w0, input logic [NM-1:0] m,
                             input logic [AW-1:0] a0, input logic [DW-1:0] d,
                             input bit c1, input logic [AW-1:0] a1);
    logic [DW-1:0] lane_mask;
    csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
    if (mdl_ready) begin
      if (!c1) exp_d1 = mdl[a1];
      if (!c0 && w0) exp_d0 = mdl[a0];
      if (!c0 && !w0) begin
        for (int i = 0; i < NM; i++) begin
          if (m[i]) begin
            lane_mask = 32'hFF << (8 * i);
            mdl[a0] = (mdl[a0] & ~lane_mask) | (d & lane_mask);
          end
        end
      end
    end
    tick();
    idle_inputs();
  endtask

  task automatic count_clear(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (init_busy && n < 200);
  endtask

  task automatic test_reset();
    int n;
    mdl_ready = 0;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (dout0 !== 32'h0) begin failures++; $display("FAIL reset_dout0 got=%h want=%h", dout0, 32'h0); end
    checks++; if (dout1 !== 32'h0) begin failures++; $display("FAIL reset_dout1 got=%h want=%h", dout1, 32'h0); end
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b want=1", init_busy); end
    checks++; if (nc_dout0 !== 32'h0) begin failures++; $display("FAIL reset_nc_dout0 got=%h want=%h", nc_dout0, 32'h0); end
    checks++; if (nc_init_busy !== 1'b1) begin failures++; $display("FAIL reset_nc_busy got=%b want=1", nc_init_busy); end
    model_reset();
    rst_n = 1'b1;
    count_clear(n);
    checks++; if (n != DEPTH || init_busy !== 1'b0) begin
      failures++; $display("FAIL clear_edges got=%0d busy=%b want=%0d busy=0", n, init_busy, DEPTH);
    end
    mdl_ready = 1;
  endtask

  task automatic test_masked_write();
    drive_cycle(1'b0, 1'b0, 4'hF, 7'd5, 32'hAABBCCDD, 1'b1, 7'd0);
    drive_cycle(1'b0, 1'b0, 4'b0101, 7'd5, 32'h11223344, 1'b1, 7'd0);
    drive_cycle(1'b0, 1'b1, 4'h0, 7'd5, 32'h0, 1'b0, 7'd5);
    checks++; if (dout0 !== 32'hAA22CC44) begin failures++; $display("FAIL mask_dout0 got=%h want=%h", dout0, 32'hAA22CC44); end
    checks++; if (dout1 !== 32'hAA22CC44) begin failures++; $display("FAIL mask_dout1 got=%h want=%h", dout1, 32'hAA22CC44); end
    drive_cycle(1'b0, 1'b0, 4'h0, 7'd5, 32'hFFFFFFFF, 1'b1, 7'd0);
    checks++; if (dout0 !== 32'hAA22CC44) begin failures++; $display("FAIL write_hold_dout0 got=%h want=%h", dout0, 32'hAA22CC44); end
    drive_cycle(1'b0, 1'b1, 4'h0, 7'd5, 32'h0, 1'b1, 7'd0);
    checks++; if (dout0 !== 32'hAA22CC44) begin failures++; $display("FAIL zero_mask_dout0 got=%h want=%h", dout0, 32'hAA22CC44); end
  endtask

  task automatic test_collision();
    drive_cycle(1'b0, 1'b0, 4'hF, 7'd9, 32'h1, 1'b1, 7'd0);
    drive_cycle(1'b0, 1'b0, 4'hF, 7'd9, 32'h2, 1'b0, 7'd9);
    checks++; if (dout1 !== 32'h1) begin failures++; $display("FAIL collision_old got=%h want=%h", dout1, 32'h1); end
    drive_cycle(1'b1, 1'b1, 4'h0, 7'd0, 32'h0, 1'b0, 7'd9);
    checks++; if (dout1 !== 32'h2) begin failures++; $display("FAIL collision_new got=%h want=%h", dout1, 32'h2); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NM'($urandom),
                  AW'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
      checks++; if (dout0 !== exp_d0) begin failures++; $display("FAIL random_dout0 cyc=%0d got=%h want=%h", k, dout0, exp_d0); end
      checks++; if (dout1 !== exp_d1) begin failures++; $display("FAIL random_dout1 cyc=%0d got=%h want=%h", k, dout1, exp_d1); end
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    for (int a = 0; a < DEPTH; a++) drive_cycle(1'b0, 1'b0, 4'hF, AW'(a), $urandom | 32'h1, 1'b1, '0);
    mdl_ready = 0;
    rst_n = 1'b0;
    tick();
    model_reset();
    rst_n = 1'b1;
    n = 0;
    do begin
      drive_cycle(1'b0, 1'b0, 4'hF, 7'd3, 32'hFFFFFFFF, 1'b0, 7'd3);
      n++;
      checks++; if (dout0 !== 32'h0 || dout1 !== 32'h0) begin
        failures++; $display("FAIL busy_hold edge=%0d got=%h/%h want=0/0", n, dout0, dout1);
      end
    end while (init_busy && n < 200);
    checks++; if (n != DEPTH) begin failures++; $display("FAIL busy_clear_edges got=%0d want=%0d", n, DEPTH); end
    mdl_ready = 1;
    for (int a = 0; a < DEPTH; a++) begin
      drive_cycle(1'b0, 1'b1, 4'h0, AW'(a), 32'h0, 1'b0, AW'(DEPTH - 1 - a));
      checks++; if (dout0 !== 32'h0 || dout1 !== 32'h0) begin
        failures++; $display("FAIL cleared_word addr=%0d got=%h/%h want=0/0", a, dout0, dout1);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    mdl_ready = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 59; k++) tick();
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL midclear_busy got=%b want=1", init_busy); end
    rst_n = 1'b0;
    tick();
    checks++; if (dout0 !== 32'h0 || dout1 !== 32'h0 || init_busy !== 1'b1) begin
      failures++; $display("FAIL midclear_reset got=%h/%h busy=%b want=0/0 busy=1", dout0, dout1, init_busy);
    end
    model_reset();
    rst_n = 1'b1;
    count_clear(n);
    checks++; if (n != DEPTH) begin failures++; $display("FAIL midclear_restart got=%0d want=%0d", n, DEPTH); end
    mdl_ready = 1;
  endtask

  task automatic test_no_clear();
    drive_cycle(1'b0, 1'b0, 4'hF, 7'd7, 32'hDEADBEEF, 1'b1, 7'd0);
    drive_cycle(1'b0, 1'b1, 4'h0, 7'd7, 32'h0, 1'b0, 7'd7);
    checks++; if (nc_dout0 !== 32'hDEADBEEF) begin failures++; $display("FAIL nc_pre_dout0 got=%h want=%h", nc_dout0, 32'hDEADBEEF); end
    mdl_ready = 0;
    rst_n = 1'b0;
    tick();
    checks++; if (nc_dout0 !== 32'h0 || nc_dout1 !== 32'h0 || nc_init_busy !== 1'b1) begin
      failures++; $display("FAIL nc_reset got=%h/%h busy=%b want=0/0 busy=1", nc_dout0, nc_dout1, nc_init_busy);
    end
    rst_n = 1'b1;
    tick();
    checks++; if (nc_init_busy !== 1'b0) begin failures++; $display("FAIL nc_ready got=%b want=0", nc_init_busy); end
    drive_cycle(1'b0, 1'b1, 4'h0, 7'd7, 32'h0, 1'b0, 7'd7);
    checks++; if (nc_dout0 !== 32'hDEADBEEF || nc_dout1 !== 32'hDEADBEEF) begin
      failures++; $display("FAIL nc_keep got=%h/%h want=%h", nc_dout0, nc_dout1, 32'hDEADBEEF);
    end
  endtask

  initial begin
    mdl_ready = 0;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_masked_write();
    test_collision();
    test_random();
    test_busy_ignore();
    test_reset_mid_clear();
    test_no_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
